// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared state encoding and constants for the k-means control slice
package kmeans_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_RDACC, S_DIV, S_UPDATE, S_FINISH
  } state_t;
  localparam int PIPE_LATENCY = 5;
  localparam int CIDX_W = 2;
endpackage

// File: rtl/kmeans_k3n2_control_div.sv
// kmeans_div_seq: restoring divider, one quotient bit per cycle, floor(dividend/divisor)
module kmeans_div_seq #(
  parameter int DVD_W = 16,
  parameter int DVR_W = 8,
  parameter int QUO_W = DVD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVR_W-1:0] divisor,
  output logic             div_done,
  output logic [QUO_W-1:0] quotient
);
  localparam int CW = $clog2(DVD_W + 1);
  logic [CW-1:0]    r_cnt;
  logic [DVR_W-1:0] r_rem, r_dvr;
  logic [DVD_W-1:0] r_q;
  logic             r_done;
  logic [DVR_W:0]   w_sh;
  logic [DVR_W+1:0] w_diff;
  logic             w_ge;
  assign w_sh   = {r_rem, r_q[DVD_W-1]};
  assign w_diff = {1'b0, w_sh} - {2'b00, r_dvr};
  assign w_ge   = ~w_diff[DVR_W+1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvr  <= '0;
      r_q    <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (div_start) begin
        r_rem <= '0;
        r_q   <= dividend;
        r_dvr <= divisor;
        r_cnt <= CW'(DVD_W);
      end else if (r_cnt != '0) begin
        r_rem  <= w_ge ? w_diff[DVR_W-1:0] : w_sh[DVR_W-1:0];
        r_q    <= {r_q[DVD_W-2:0], w_ge};
        r_cnt  <= r_cnt - 1'b1;
        r_done <= r_cnt == CW'(1);
      end
    end
  assign div_done = r_done;
  assign quotient = r_q[QUO_W-1:0];
endmodule

// File: rtl/kmeans_k3n2_control.sv
// kmeans_k3n2_control: iteration sequencer for the 3-centroid, 2-dimension k-means datapath
module kmeans_k3n2_control
  import kmeans_pkg::*;
#(
  parameter int input_data_width         = 8,
  parameter int input_data_qty           = 255,
  parameter int input_data_qty_bit_width = 8,
  parameter int acc_width                = 16,
  parameter int pipe_latency             = PIPE_LATENCY,
  parameter int max_iterations           = 16,
  parameter int iter_width               = 5,
  parameter logic [input_data_width-1:0] k0_d0_initial = 0,
  parameter logic [input_data_width-1:0] k0_d1_initial = 0,
  parameter logic [input_data_width-1:0] k1_d0_initial = 1,
  parameter logic [input_data_width-1:0] k1_d1_initial = 1,
  parameter logic [input_data_width-1:0] k2_d0_initial = 2,
  parameter logic [input_data_width-1:0] k2_d1_initial = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                converged,
  output logic [iter_width-1:0]               iteration_count,
  output logic [input_data_qty_bit_width-1:0] input_ram_rd_address,
  output logic                                acc_clear,
  output logic                                acc_enable,
  output logic                                rd_acc_en,
  output logic [CIDX_W-1:0]                   rd_acc_centroid,
  input  logic [acc_width-1:0]                acc0_in,
  input  logic [acc_width-1:0]                acc1_in,
  input  logic [input_data_qty_bit_width-1:0] acc_counter_in,
  output logic [input_data_width-1:0]         k0d0,
  output logic [input_data_width-1:0]         k0d1,
  output logic [input_data_width-1:0]         k1d0,
  output logic [input_data_width-1:0]         k1d1,
  output logic [input_data_width-1:0]         k2d0,
  output logic [input_data_width-1:0]         k2d1
);
  localparam int DW = input_data_width;
  localparam int QW = input_data_qty_bit_width;
  localparam logic [QW-1:0] LAST_ADDR = QW'(input_data_qty - 1);
  localparam logic [iter_width-1:0] ITER_CAP = iter_width'(max_iterations);
  localparam logic [2:0][1:0][DW-1:0] INIT = {k2_d1_initial, k2_d0_initial,
    k1_d1_initial, k1_d0_initial, k0_d1_initial, k0_d0_initial};
  state_t                  r_state, w_nxt;
  logic [QW-1:0]           r_addr;
  logic [pipe_latency-1:0] r_sr, w_sr_nxt;
  logic [CIDX_W-1:0]       r_idx;
  logic [2:0][1:0][DW-1:0] r_k, r_new;
  logic [iter_width-1:0]   r_iter;
  logic                    r_conv;
  logic                    w_div_start, w_done0, w_done1, w_div_done;
  logic [DW-1:0]           w_q0, w_q1;
  logic                    w_empty, w_last_idx, w_same, w_stream_last;
  assign w_empty       = acc_counter_in == '0;
  assign w_last_idx    = r_idx == CIDX_W'(2);
  assign w_same        = r_new == r_k;
  assign w_stream_last = r_addr == LAST_ADDR;
  assign w_div_start   = (r_state == S_RDACC) && !w_empty;
  assign w_div_done    = w_done0 && w_done1;
  // bit 0 marks an address issued this cycle; the top bit lines up with its pipeline result
  assign w_sr_nxt      = pipe_latency'({r_sr, r_state == S_STREAM});
  kmeans_div_seq #(.DVD_W(acc_width), .DVR_W(QW), .QUO_W(DW)) u_div0 (
    .clk(clk), .rst(rst), .div_start(w_div_start), .dividend(acc0_in),
    .divisor(acc_counter_in), .div_done(w_done0), .quotient(w_q0)
  );
  kmeans_div_seq #(.DVD_W(acc_width), .DVR_W(QW), .QUO_W(DW)) u_div1 (
    .clk(clk), .rst(rst), .div_start(w_div_start), .dividend(acc1_in),
    .divisor(acc_counter_in), .div_done(w_done1), .quotient(w_q1)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else r_state <= w_nxt;
  always_comb begin
    w_nxt      = r_state;
    busy       = r_state != S_IDLE;
    done       = r_state == S_FINISH;
    acc_clear  = r_state == S_CLEAR;
    rd_acc_en  = r_state == S_RDACC;
    acc_enable = r_sr[pipe_latency-1];
    case (r_state)
      S_IDLE:   w_nxt = start ? S_CLEAR : S_IDLE;
      S_CLEAR:  w_nxt = S_STREAM;
      S_STREAM: w_nxt = w_stream_last ? S_DRAIN : S_STREAM;
      S_DRAIN:  w_nxt = (w_sr_nxt == '0) ? S_RDACC : S_DRAIN;
      S_RDACC:  w_nxt = !w_empty ? S_DIV : (w_last_idx ? S_UPDATE : S_RDACC);
      S_DIV:    w_nxt = !w_div_done ? S_DIV : (w_last_idx ? S_UPDATE : S_RDACC);
      S_UPDATE: w_nxt = (w_same || r_iter + 1'b1 == ITER_CAP) ? S_FINISH : S_CLEAR;
      S_FINISH: w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_addr <= '0;
      r_sr   <= '0;
      r_idx  <= '0;
      r_k    <= INIT;
      r_new  <= '0;
      r_iter <= '0;
      r_conv <= 1'b0;
    end else begin
      r_sr <= w_sr_nxt;
      case (r_state)
        S_IDLE: if (start) begin
          r_k    <= INIT;
          r_iter <= '0;
          r_conv <= 1'b0;
        end
        S_CLEAR: begin
          r_addr <= '0;
          r_idx  <= '0;
        end
        S_STREAM: if (!w_stream_last) r_addr <= r_addr + 1'b1;
        S_RDACC: if (w_empty) begin
          r_new[r_idx] <= r_k[r_idx];
          if (!w_last_idx) r_idx <= r_idx + 1'b1;
        end
        S_DIV: if (w_div_done) begin
          r_new[r_idx] <= {w_q1, w_q0};
          if (!w_last_idx) r_idx <= r_idx + 1'b1;
        end
        S_UPDATE: begin
          r_k    <= r_new;
          r_iter <= r_iter + 1'b1;
          if (w_same) r_conv <= 1'b1;
        end
        default: ;
      endcase
    end
  assign converged            = r_conv;
  assign iteration_count      = r_iter;
  assign input_ram_rd_address = r_addr;
  assign rd_acc_centroid      = r_idx;
  assign k0d0 = r_k[0][0];
  assign k0d1 = r_k[0][1];
  assign k1d0 = r_k[1][0];
  assign k1d1 = r_k[1][1];
  assign k2d0 = r_k[2][0];
  assign k2d1 = r_k[2][1];
endmodule

// File: doc/kmeans_k3n2_control.md
# kmeans_k3n2_control

Iteration sequencer for the 3-centroid, 2-dimension k-means datapath. It holds the six centroid registers and sweeps the input-data RAM address so the distance pipeline streams every sample. It drives the accumulator block's clear, enable and read port, then divides each per-centroid sum by its count to form new centroids. It repeats until the centroids stop changing or an iteration cap is reached; it sits in `kmeans_k3n2_top` between the input RAM, pipeline and `kmeans_acc_block_k3n2`.

## Interface
- `input_data_width`, 8: sample/centroid width.
- `input_data_qty`, 255: samples per sweep; must be ≤ 2^`input_data_qty_bit_width` − 1 so a centroid count never wraps.
- `input_data_qty_bit_width`, 8: address and count width.
- `acc_width`, 16: accumulator sum width.
- `pipe_latency`, 5: cycles from RAM address to pipeline `selected_centroid`.
- `max_iterations`, 16: iteration cap, ≥ 1.
- `iter_width`, 5: iteration counter width.
- `kX_dY_initial`, X∈0..2, Y∈0..1: reset/start centroid values. Defaults: k0 = 0,0; k1 = 1,1; k2 = 2,2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at run end.
- `converged` out 1: last run ended on convergence; holds until the next `start`.
- `iteration_count` out `iter_width`: iterations completed in the current/last run.
- `input_ram_rd_address` out `input_data_qty_bit_width`: input RAM address.
- `acc_clear` out 1: active-high synchronous clear to the acc block's `rst`.
- `acc_enable` out 1: accumulate strobe.
- `rd_acc_en` out 1; `rd_acc_centroid` out 2: acc read port.
- `acc0_in`, `acc1_in` in `acc_width`; `acc_counter_in` in `input_data_qty_bit_width`: acc read data, combinational from `rd_acc_centroid`.
- `k0d0`…`k2d1` out `input_data_width` ×6: registered current centroids to the pipeline.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, RDACC, DIV, UPDATE, FINISH.
- IDLE: `start`=1 loads all centroids with `*_initial`, clears `iteration_count` and `converged`, then goes to CLEAR. `start` outside IDLE is ignored.
- CLEAR (1 cycle): `acc_clear`=1, address←0, then STREAM.
- STREAM (`input_data_qty` cycles): address increments 0..qty−1, and a valid bit enters a `pipe_latency`-deep shift register. After the last address, go to DRAIN.
- `acc_enable` = tail of the valid shift register, exactly `pipe_latency` cycles after each address. It is asserted exactly `input_data_qty` times per iteration.
- DRAIN: wait until the shift register is empty, then go to RDACC with centroid index 0.
- RDACC (1 cycle): `rd_acc_en`=1, `rd_acc_centroid`=index. Capture `acc0_in`, `acc1_in` and `acc_counter_in`.
  - Count = 0: skip DIV; the new centroid equals the old one.
  - Otherwise go to DIV.
- DIV: two `kmeans_div_seq` instances run in parallel (sum / count, floor). Quotient truncated to `input_data_width`.
  - Store the new centroid.
  - index<2 → RDACC with index+1; else UPDATE.
- UPDATE (1 cycle): compare the six new values with the current ones, load the new values, increment `iteration_count`.
  - All equal → `converged`←1, go to FINISH.
  - Otherwise, `iteration_count` = `max_iterations` → FINISH.
  - Otherwise → CLEAR.
- FINISH: `done`=1 for one cycle, then IDLE. Centroids hold their final values until the next `start`.

## Timing
- Reset values:
  - all 1-bit outputs 0;
  - address 0, `rd_acc_centroid` 0, `iteration_count` 0;
  - centroids = `*_initial`;
  - state IDLE; shift register cleared.
- `busy`=1 from the cycle after `start` is accepted through FINISH inclusive; 0 in IDLE.
- Divider latency: `acc_width`+1 cycles from `div_start` to `div_done`.
- Iteration length with all centroids non-empty: 1 + qty + `pipe_latency` + 3·(1 + `acc_width` + 1) + 1 cycles. An empty centroid saves `acc_width`+1 cycles.
- Centroid registers change only in UPDATE, so they are stable throughout STREAM/DRAIN.
- `rd_acc_en` is never high while `acc_enable` is high.
- Reset asserted mid-run: immediate return to reset values. Any partial iteration is discarded and `done` is not pulsed.

## Structure
- Package `kmeans_pkg`: state encoding, pipeline latency constant, centroid-index width (2).
- Sub-module `kmeans_div_seq`: restoring divider.
  - Parameters: dividend width, divisor width.
  - Ports: `div_start`, dividend, divisor, `div_done`, quotient.
  - Same `clk`/`rst`.

## Test plan
- Use a stub acc model returning scripted sums and counts for every test below.
- Single sweep: qty=255, pulse `start` → address goes 0..254 once; exactly 255 `acc_enable` pulses, first one 5 cycles after address 0; one `acc_clear` before STREAM.
- Division: k0 (1000, 500, count 10), k1 (255, 0, count 255), k2 (7, 7, count 2) → centroids (100,50), (1,0), (3,3).
- Empty centroid: count 0 for k1 → k1 unchanged; DIV state skipped (iteration shorter by 17 cycles).
- Convergence: stub returns sums reproducing the current centroids → `converged`=1 and `done` after iteration 1, `iteration_count`=1.
- Cap: stub always alternates results → `done` after 16 iterations, `converged`=0, `iteration_count`=16.
- Asynchronous reset mid-DIV, plus `start` pulsed while busy:
  - the ignored `start` has no effect;
  - after reset, outputs return to reset values and no `done` pulse is produced;
  - a new `start` runs cleanly.
